// File: rtl/eight_bit_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// eight_bit_shift_add_multiplier
//
// Purpose:
//   Sequential unsigned 8x8 -> 16-bit multiplier. It runs one shift-add
//   iteration per clock through a single 8-bit ripple-carry adder, so one
//   multiply takes eight iterations plus one DONE cycle. It is meant as a
//   small multiply stage in front of wider arithmetic.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous, active-high reset (priority over all)
//   start    in   1   begin a multiply; only looked at in IDLE
//   a        in   8   multiplicand, captured when start is accepted
//   b        in   8   multiplier, captured when start is accepted
//   busy     out  1   high while iterations run (state RUN)
//   done     out  1   one-cycle pulse when product has just been updated
//   product  out 16   unsigned a*b, held until the next result or reset
//
// Also in this file:
//   eight_bit_ripple_carry_adder -- the 8-bit adder used by the datapath.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// eight_bit_ripple_carry_adder
//
// Purpose:
//   Plain 8-bit ripple-carry adder built from a chain of full-adder cells.
//
// Ports:
//   a     in   8   operand A
//   b     in   8   operand B
//   cin   in   1   carry in
//   cout  out  1   carry out of bit 7
//   sum   out  8   a + b + cin, low 8 bits
// ---------------------------------------------------------------------------
module eight_bit_ripple_carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [7:0] sum
);

  // carry[i] is the carry into bit i; carry[8] leaves the adder.
  logic [8:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_fa
      logic prop;

      assign prop          = a[gi] ^ b[gi];
      assign sum[gi]       = prop ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (prop & carry[gi]);
    end
  endgenerate

  assign cout = carry[8];

endmodule

module eight_bit_shift_add_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Index of the last iteration: cnt runs 0..7, for eight iterations.
  localparam logic [3:0] LAST_ITER = 4'd7;

  // -------------------------------------------------------------------------
  // Registers and their next-state values
  // -------------------------------------------------------------------------
  logic [1:0]  state_reg,   state_next;
  logic [7:0]  m_reg,       m_next;        // multiplicand
  logic [7:0]  acc_reg,     acc_next;      // accumulator / upper half
  logic [7:0]  q_reg,       q_next;        // multiplier / lower half
  logic [3:0]  cnt_reg,     cnt_next;      // iteration counter
  logic [15:0] product_reg, product_next;

  // -------------------------------------------------------------------------
  // Adder hookup
  // -------------------------------------------------------------------------
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;

  // The current multiplier LSB chooses whether M is added in this iteration.
  assign add_b = q_reg[0] ? m_reg : 8'h00;

  eight_bit_ripple_carry_adder u_adder (
    .a    (acc_reg),
    .b    (add_b),
    .cin  (1'b0),
    .cout (add_cout),
    .sum  (add_sum)
  );

  // The 17-bit {cout, sum, Q} shifted right by one. Its 16 bits become the
  // new {A, Q}. After the last iteration they are also the full product.
  logic [15:0] shifted;

  assign shifted = {add_cout, add_sum, q_reg[7:1]};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    m_next       = m_reg;
    acc_next     = acc_reg;
    q_next       = q_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          m_next     = a;
          q_next     = b;
          acc_next   = 8'h00;
          cnt_next   = 4'd0;
          state_next = RUN;
        end
      end

      RUN: begin
        acc_next = shifted[15:8];
        q_next   = shifted[7:0];
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_ITER) begin
          product_next = shifted;
          state_next   = DONE;
        end
      end

      DONE: begin
        // DONE lasts exactly one cycle. A start seen here is dropped.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      m_reg       <= 8'h00;
      acc_reg     <= 8'h00;
      q_reg       <= 8'h00;
      cnt_reg     <= 4'd0;
      product_reg <= 16'h0000;
    end else begin
      state_reg   <= state_next;
      m_reg       <= m_next;
      acc_reg     <= acc_next;
      q_reg       <= q_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: registers and state decode only, so there is no path from
  // the inputs straight to the outputs.
  // -------------------------------------------------------------------------
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;

endmodule
